serv_alu_seq: RTL
=================

// Module: serv_alu_seq
// PURPOSE
// Self-sequencing multi-cycle ALU. Accepts two XLEN-bit operands and an opcode over a valid/ready handshake.
// Processes them W bits per cycle, LSB first, in XLEN/W cycles, then presents the result until accepted.
// Used where area matters more than latency: coprocessor ALU, address/compare helper beside the serial core.
// Adds a start/done protocol, W-bit digits, signed/unsigned/eq compare select and abort.
// PARAMETERS
// W     1   bits processed per cycle; must divide XLEN (elaboration error otherwise)
// XLEN  32  operand/result width
// PORTS
// clk        in   1     clock, all state on rising edge
// i_rst_n    in   1     asynchronous active-low reset
// i_valid    in   1     request valid
// o_ready    out  1     block idle, request accepted when i_valid & o_ready
// i_op       in   3     000 ADD, 001 SUB, 010 SLT, 011 SLTU, 100 EQ, 101 XOR, 110 OR, 111 AND
// i_rs1      in   XLEN  operand A
// i_op_b     in   XLEN  operand B
// i_abort    in   1     synchronous cancel of the in-flight operation
// o_valid    out  1     result valid
// i_ready    in   1     result consumed when o_valid & i_ready
// o_rd       out  XLEN  result
// o_cmp      out  1     compare outcome (SLT/SLTU/EQ), 0 for other ops
// BEHAVIOUR
// - Reset (async, i_rst_n=0): state IDLE, o_ready=1, o_valid=0, o_rd=0, o_cmp=0, digit counter=0, carry=0. All take effect immediately and hold until release.
// - FSM IDLE -> RUN -> DONE -> IDLE. Let N = XLEN/W.
// - IDLE: o_ready=1.
//   - On accept: latch op, rs1 and op_b into shift registers; cnt=0.
//   - Carry register = 1 for SUB/SLT/SLTU/EQ, else 0. Goto RUN.
// - RUN: o_ready=0, o_valid=0. Each cycle, on the low W bits a,b of the shift registers:
//   - {cy,sum} = a + (b ^ {W{sub}}) + cy_r, with sub=1 for SUB/SLT/SLTU/EQ.
//   - Bool digit = a^b, a|b or a&b per op.
//   - Result register shifts right by W with the digit (sum or bool) entering at the top.
//   - eq_r &= (a==b), with eq_r initialised to 1 at accept.
//   - cy_r <= cy. Operand registers shift right by W. cnt++.
// - At cnt==N-1 the last digit is processed and the FSM goes to DONE. o_valid rises exactly N cycles after the accept edge; W=XLEN gives 1 cycle.
// - Compare, from the final digit and latched operand MSBs:
//   - SLTU: lt = ~cy_final.
//   - SLT: lt = (msbA != msbB) ? msbA : ~cy_final.
//   - EQ: eq_r.
// - For SLT/SLTU/EQ: o_rd = {XLEN-1 zeros, cmp}, o_cmp = cmp. Otherwise o_cmp=0.
// - ADD/SUB wrap modulo 2^XLEN; carry out is discarded.
// - DONE: o_valid=1; o_rd and o_cmp are stable until the handshake. On o_valid & i_ready goto IDLE; o_ready rises the following cycle (no same-cycle re-accept).
// - i_valid is ignored outside IDLE. Operand inputs are don't-care after the accept edge.
// - i_abort in RUN or DONE: goto IDLE next edge, o_valid=0, result dropped. Abort takes priority over i_ready in DONE. Abort in IDLE has no effect, and it also blocks a same-cycle accept.
// - o_rd and o_cmp hold their last value in IDLE; they are zeroed only by reset.
// - Opcode is sampled only at accept; mid-operation i_op changes have no effect.
// TESTING
// 1. W=4, ADD 0xFFFFFFFF+0x00000001 -> o_valid 8 cycles after accept, o_rd=0x00000000, o_cmp=0.
// 2. W=1, SUB 5-7 -> o_valid 32 cycles after accept, o_rd=0xFFFFFFFE; XOR 0xF0F0F0F0^0xFF00FF00 -> 0x0FF00FF0.
// 3. W=8, SLT 0x80000000 vs 0x00000001 -> o_rd=1, o_cmp=1; SLTU same operands -> o_rd=0, o_cmp=0.
// 4. W=2, EQ 0x12345678 vs 0x12345678 -> o_cmp=1; vs 0x12345679 (low digit differs) -> o_cmp=0, o_rd=0.
// 5. Hold i_ready=0 for 10 cycles after o_valid:
//    - o_valid, o_rd and o_cmp stay stable, and o_ready=0.
//    - i_valid pulses are ignored.
//    - Releasing i_ready gives o_ready=1 on the next cycle.
// 6. Abort at cnt=3 -> o_ready=1 next cycle, with no o_valid pulse. Reset asserted mid-RUN -> o_valid=0, o_rd=0, o_ready=1 immediately. A new op afterwards completes correctly.

Source files
------------

// File: rtl/serv_alu_seq_if.sv
// Request/response bundle for the digit-serial ALU: valid/ready request with
// operands and opcode, valid/ready result with compare flag and abort.
interface serv_alu_seq_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_op_b;
  logic            i_abort;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_rd;
  logic            o_cmp;

  modport master (
    output i_valid, i_op, i_rs1, i_op_b, i_abort, i_ready,
    input  o_ready, o_valid, o_rd, o_cmp
  );

  modport slave (
    input  i_valid, i_op, i_rs1, i_op_b, i_abort, i_ready,
    output o_ready, o_valid, o_rd, o_cmp
  );
endinterface

// File: rtl/serv_alu_seq.sv
// Self-sequencing digit-serial ALU: W bits per cycle, LSB first, XLEN/W cycles
// per operation, result held until the consumer takes it.
module serv_alu_seq #(
  parameter int W    = 1,
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          i_rst_n,
  serv_alu_seq_if.slave bus
);
  localparam int N  = XLEN / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (W < 1 || (XLEN % W) != 0) begin : g_bad_w
    $error("serv_alu_seq: W must divide XLEN");
  end

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_EQ   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, res_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            cy_q, eq_q, msb_a_q, msb_b_q, cmp_q;

  logic            accept, step, last;
  logic            sub, is_cmp, is_bool;
  logic [W-1:0]    da, db, dbx, dsum, dbool, dig;
  logic            cy_d, eq_d, lt_s, cmp_d;
  logic [XLEN-1:0] res_nx;

  // Abort in IDLE suppresses a same-cycle accept.
  assign accept = (state_q == S_IDLE) && bus.i_valid && !bus.i_abort;
  assign step   = (state_q == S_RUN) && !bus.i_abort;
  assign last   = (cnt_q == CW'(N - 1));

  always_comb begin
    sub     = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU) || (op_q == OP_EQ);
    is_cmp  = (op_q == OP_SLT) || (op_q == OP_SLTU) || (op_q == OP_EQ);
    is_bool = (op_q == OP_XOR) || (op_q == OP_OR) || (op_q == OP_AND);
    da      = a_q[W-1:0];
    db      = b_q[W-1:0];
    dbx     = db ^ {W{sub}};
    {cy_d, dsum} = {1'b0, da} + {1'b0, dbx} + {{W{1'b0}}, cy_q};
    case (op_q)
      OP_XOR:  dbool = da ^ db;
      OP_OR:   dbool = da | db;
      default: dbool = da & db;
    endcase
    dig  = is_bool ? dbool : dsum;
    eq_d = eq_q && (da == db);
    // Differing sign bits decide signed order directly; otherwise the borrow does.
    lt_s = (msb_a_q != msb_b_q) ? msb_a_q : ~cy_d;
    case (op_q)
      OP_SLT:  cmp_d = lt_s;
      OP_SLTU: cmp_d = ~cy_d;
      OP_EQ:   cmp_d = eq_d;
      default: cmp_d = 1'b0;
    endcase
    res_nx = (res_q >> W) | (XLEN'(dig) << (XLEN - W));
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    bus.o_rd    = rd_q;
    bus.o_cmp   = cmp_q;
    case (state_q)
      S_IDLE: begin
        bus.o_ready = 1'b1;
        if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.i_abort) state_d = S_IDLE;
        else if (last)   state_d = S_DONE;
      end
      S_DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_abort || bus.i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      eq_q    <= 1'b0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
      cmp_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.i_op;
      a_q     <= bus.i_rs1;
      b_q     <= bus.i_op_b;
      msb_a_q <= bus.i_rs1[XLEN-1];
      msb_b_q <= bus.i_op_b[XLEN-1];
      cnt_q   <= '0;
      eq_q    <= 1'b1;
      cy_q    <= (bus.i_op == OP_SUB) || (bus.i_op == OP_SLT) ||
                 (bus.i_op == OP_SLTU) || (bus.i_op == OP_EQ);
    end else if (step) begin
      a_q   <= a_q >> W;
      b_q   <= b_q >> W;
      res_q <= res_nx;
      cy_q  <= cy_d;
      eq_q  <= eq_d;
      cnt_q <= cnt_q + CW'(1);
      // Visible result only changes when an operation completes.
      if (last) begin
        rd_q  <= is_cmp ? XLEN'(cmp_d) : res_nx;
        cmp_q <= cmp_d;
      end
    end
  end
endmodule
